alu_operand_loader: RTL and testbench
=====================================

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

Interface
REQ-001 The block SHALL expose parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum number of clk cycles allowed between the first and second byte of a frame (40 ms at 25 MHz).
REQ-002 The block SHALL expose parameter CNT_W, default 20, meaning the timeout counter width; CNT_W SHALL be at least clog2(TIMEOUT_CYCLES+1).
REQ-003 Port clk  input  1  system clock, 25 MHz nominal; one clock, all state on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port data_in  input  8  byte from the external host; may change at any time while strobe_in is low.
REQ-006 Port strobe_in  input  1  asynchronous byte strobe from the host; a rising edge marks data_in valid.
REQ-007 Port alu_word  output  16  packed ALU operand word {op[2:0], B[4:0], A[7:0]} driven to the ALU operand input.
REQ-008 Port word_valid  output  1  one-cycle pulse when alu_word has just been updated.
REQ-009 Port busy  output  1  high while a frame is half-received.
REQ-010 Port timeout_err  output  1  sticky flag: last frame was abandoned by timeout.
REQ-011 Port frame_cnt  output  4  count of completed frames, modulo 16.

Function
REQ-012 strobe_in SHALL pass through a two-flop synchronizer; a rising edge SHALL be detected when the second sync stage is 1 and its delayed copy is 0 (one detect pulse per edge).
REQ-013 data_in SHALL be sampled on the detect-pulse cycle, which is the third rising clk edge after strobe_in rises; the host holds data_in stable for at least 4 cycles after the strobe rises.
REQ-014 The FSM SHALL have states IDLE and GOT_A.
REQ-015 IDLE + detect: capture data_in as A into a holding register, clear the timeout counter, go to GOT_A.
REQ-016 GOT_A + detect: load alu_word <= {data_in[7:5], data_in[4:0], A_hold}, pulse word_valid on the following cycle, increment frame_cnt (15 wraps to 0), clear timeout_err, go to IDLE.
REQ-017 In GOT_A without a detect, the timeout counter SHALL increment each cycle; when it reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, set timeout_err, and leave alu_word and frame_cnt unchanged.
REQ-018 Simultaneous detect and timeout expiry in GOT_A: the detect wins and the frame completes.
REQ-019 In IDLE the timeout counter SHALL hold at 0.
REQ-020 busy SHALL equal (state == GOT_A), registered.
REQ-021 alu_word SHALL hold its value between frames; the ALU consumes it combinationally.
REQ-022 word_valid latency SHALL be exactly 4 cycles from the strobe rising edge of the second byte.

Reset
REQ-023 On rst_n low, all outputs and state SHALL clear asynchronously: alu_word=0x0000, word_valid=0, busy=0, timeout_err=0, frame_cnt=0, FSM=IDLE, sync flops=0, counter=0.
REQ-024 Reset asserted mid-frame SHALL discard the held A byte; the next byte after reset release is treated as A.
REQ-025 Reset de-assertion is assumed synchronous to clk by the top level; a strobe_in already high at release SHALL NOT generate a detect.

Structure
REQ-026 Shared package alu_pkg SHALL hold A_W=8, B_W=5, OP_W=3, the word field offsets (A at 0, B at 8, OP at 13), the opcode enum (ADD=3'b000, SUB=3'b001, others reserved), and the loader state enum.
REQ-027 One sub-module sync_edge (2FF synchronizer, rising-edge pulse, async active-low reset) SHALL be instantiated for strobe_in.
REQ-028 The implementation SHALL be synthesizable and free of latches; the expected size is about 150 lines.

Verification
REQ-029 Reset, then bytes 0x05 and 0x03 (op=000, B=3): alu_word=0x0305, one word_valid pulse 4 cycles after the second strobe, frame_cnt=1.
REQ-030 Bytes 0x0A and 0x24 (op=001, B=4): alu_word=0x240A, frame_cnt increments, busy high only between the two bytes.
REQ-031 First byte only, then wait TIMEOUT_CYCLES (use parameter 16): busy drops, timeout_err=1, alu_word unchanged; the next full frame clears timeout_err.
REQ-032 Second strobe on the exact timeout-expiry cycle: the frame completes and timeout_err stays 0.
REQ-033 Sixteen back-to-back frames: frame_cnt wraps to 0; a strobe held high for 10 cycles yields a single byte.
REQ-034 rst_n pulsed low between the two bytes: outputs go to reset values immediately, and the next two bytes form a correct frame.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand loader: field widths, word layout,
// opcode encoding and the loader FSM state type.
package alu_pkg;

   localparam int unsigned A_W    = 8;
   localparam int unsigned B_W    = 5;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned WORD_W = A_W + B_W + OP_W;

   localparam int unsigned A_OFF  = 0;
   localparam int unsigned B_OFF  = 8;
   localparam int unsigned OP_OFF = 13;

   // Only ADD and SUB are defined; remaining encodings are reserved.
   typedef enum logic [OP_W-1:0] {
      OpAdd = 3'b000,
      OpSub = 3'b001
   } alu_op_e;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StGotA = 1'b1
   } loader_state_e;

   // Assemble the packed operand word {op, B, A}.
   function automatic logic [WORD_W-1:0] pack_word(input logic [OP_W-1:0] op,
                                                   input logic [B_W-1:0]  b,
                                                   input logic [A_W-1:0]  a);
      logic [WORD_W-1:0] w;
      w = '0;
      w[OP_OFF +: OP_W] = op;
      w[B_OFF +: B_W]   = b;
      w[A_OFF +: A_W]   = a;
      return w;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with single-cycle rising-edge detect.
// A level already high when reset releases is not reported as an edge: the
// detector only arms after the synchronized input has been seen low.
module sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic rise
);

   logic       s1;
   logic       s2;
   logic       s2_d;
   logic [1:0] primed;
   logic       armed;

   // Synchronizer chain, delayed copy and arming logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s2_d   <= 1'b0;
         primed <= 2'b00;
         armed  <= 1'b0;
      end else begin
         s1     <= async_in;
         s2     <= s1;
         s2_d   <= s2;
         // primed[1] marks that s2 now holds a real sample rather than the reset value
         primed <= {primed[0], 1'b1};
         armed  <= armed | (primed[1] & ~s2);
      end
   end

   assign rise = s2 & ~s2_d & armed;

endmodule

// File: rtl/alu_operand_loader.sv
// Collects two host bytes per frame (A, then {op, B}) and presents the packed
// operand word to the ALU, with a timeout if the second byte never arrives.
module alu_operand_loader
   import alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned CNT_W          = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        data_in,
   input  logic              strobe_in,
   output logic [WORD_W-1:0] alu_word,
   output logic              word_valid,
   output logic              busy,
   output logic              timeout_err,
   output logic [3:0]        frame_cnt
);

   loader_state_e    state_q;
   loader_state_e    state_d;
   logic             detect;
   logic [CNT_W-1:0] cnt_q;
   logic [A_W-1:0]   a_hold_q;
   logic             load_q;
   logic             cnt_at_max;
   logic             capture_a;
   logic             load_word;
   logic             expire;

   sync_edge u_sync_edge (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (strobe_in),
      .rise     (detect)
   );

   assign cnt_at_max = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a detect in GOT_A takes priority over timeout expiry.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (detect) state_d = StGotA;
         StGotA:  if (detect || cnt_at_max) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Decoded FSM actions.
   always_comb begin
      capture_a = 1'b0;
      load_word = 1'b0;
      expire    = 1'b0;
      unique case (state_q)
         StIdle: capture_a = detect;
         StGotA: begin
            load_word = detect;
            expire    = ~detect & cnt_at_max;
         end
         default: ;
      endcase
   end

   // Datapath: held A byte, timeout counter, output word and status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_hold_q    <= '0;
         cnt_q       <= '0;
         alu_word    <= '0;
         load_q      <= 1'b0;
         word_valid  <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         if (capture_a) begin
            a_hold_q <= data_in;
         end
         // Counter runs only while waiting for the second byte; zero otherwise.
         if (state_q == StGotA && !load_word && !expire) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end else begin
            cnt_q <= '0;
         end
         if (load_word) begin
            alu_word    <= pack_word(data_in[7:5], data_in[4:0], a_hold_q);
            frame_cnt   <= frame_cnt + 4'd1;
            timeout_err <= 1'b0;
         end else if (expire) begin
            timeout_err <= 1'b1;
         end
         // word_valid trails the word update by one cycle.
         load_q     <= load_word;
         word_valid <= load_q;
         busy       <= (state_d == StGotA);
      end
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short timeout (16 cycles).
module tb_alu_operand_loader;

   logic        clk;
   logic        rst_n;
   logic [7:0]  data_in;
   logic        strobe_in;
   logic [15:0] alu_word;
   logic        word_valid;
   logic        busy;
   logic        timeout_err;
   logic [3:0]  frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   alu_operand_loader #(
      .TIMEOUT_CYCLES (16),
      .CNT_W          (5)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .strobe_in   (strobe_in),
      .alu_word    (alu_word),
      .word_valid  (word_valid),
      .busy        (busy),
      .timeout_err (timeout_err),
      .frame_cnt   (frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Raise strobe with data at a negedge, keep it high for 'hold' cycles, and
   // record word_valid after each of the first 8 rising edges (bit k-1 = edge k).
   task automatic send_byte(input logic [7:0] b, input int hold, output logic [7:0] mask);
      int n;
      mask = '0;
      n = (hold + 3 > 8) ? hold + 3 : 8;
      @(negedge clk);
      data_in   = b;
      strobe_in = 1'b1;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         if (k <= 8) mask[k-1] = word_valid;
         if (k == hold) strobe_in = 1'b0;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " alu_word"}, 32'(alu_word), 32'h0000);
      check({tag, " word_valid"}, 32'(word_valid), 32'h0);
      check({tag, " busy"}, 32'(busy), 32'h0);
      check({tag, " timeout_err"}, 32'(timeout_err), 32'h0);
      check({tag, " frame_cnt"}, 32'(frame_cnt), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] m;
      logic [3:0] exp_cnt;

      rst_n     = 1'b0;
      data_in   = 8'h00;
      strobe_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      // Basic frame: A=0x05, op=000 B=3.
      send_byte(8'h05, 4, m);
      check("f1 first wv", 32'(m), 32'h00);
      check("f1 busy mid", 32'(busy), 32'h1);
      send_byte(8'h03, 4, m);
      check("f1 wv at cycle 4", 32'(m), 32'h08);
      check("f1 alu_word", 32'(alu_word), 32'h0305);
      check("f1 frame_cnt", 32'(frame_cnt), 32'h1);
      check("f1 busy after", 32'(busy), 32'h0);

      // SUB frame: A=0x0A, op=001 B=4.
      send_byte(8'h0A, 4, m);
      check("f2 busy mid", 32'(busy), 32'h1);
      send_byte(8'h24, 4, m);
      check("f2 wv", 32'(m), 32'h08);
      check("f2 alu_word", 32'(alu_word), 32'h240A);
      check("f2 frame_cnt", 32'(frame_cnt), 32'h2);
      check("f2 busy after", 32'(busy), 32'h0);

      // Timeout: GOT_A entered at edge 3, expires 16 edges later (edge 19).
      send_byte(8'h77, 4, m);
      repeat (10) @(posedge clk);
      #1;
      check("to busy before expiry", 32'(busy), 32'h1);
      check("to err before expiry", 32'(timeout_err), 32'h0);
      @(posedge clk);
      #1;
      check("to busy at expiry", 32'(busy), 32'h0);
      check("to err at expiry", 32'(timeout_err), 32'h1);
      check("to alu_word kept", 32'(alu_word), 32'h240A);
      check("to frame_cnt kept", 32'(frame_cnt), 32'h2);
      send_byte(8'h11, 4, m);
      send_byte(8'h22, 4, m);
      check("to recover alu_word", 32'(alu_word), 32'h2211);
      check("to recover err cleared", 32'(timeout_err), 32'h0);
      check("to recover frame_cnt", 32'(frame_cnt), 32'h3);

      // Second detect lands on the expiry cycle: strobe 16 cycles after the first.
      send_byte(8'h33, 4, m);
      repeat (8) @(posedge clk);
      send_byte(8'h44, 4, m);
      check("race wv", 32'(m), 32'h08);
      check("race alu_word", 32'(alu_word), 32'h4433);
      check("race err", 32'(timeout_err), 32'h0);
      check("race frame_cnt", 32'(frame_cnt), 32'h4);

      // Sixteen back-to-back frames; frame_cnt passes through the 15->0 wrap.
      exp_cnt = 4'd4;
      for (int i = 0; i < 16; i++) begin
         send_byte(8'(i), 4, m);
         send_byte(8'h20 | 8'(i), 4, m);
         exp_cnt = exp_cnt + 4'd1;
         check($sformatf("b2b frame_cnt %0d", i), 32'(frame_cnt), 32'(exp_cnt));
      end
      check("b2b last alu_word", 32'(alu_word), 32'h2F0F);

      // Long strobe counts as one byte only.
      send_byte(8'h55, 10, m);
      check("long strobe busy", 32'(busy), 32'h1);
      check("long strobe frame_cnt", 32'(frame_cnt), 32'h4);
      check("long strobe wv", 32'(m), 32'h00);
      send_byte(8'h66, 4, m);
      check("long strobe alu_word", 32'(alu_word), 32'h6655);
      check("long strobe frame_cnt after", 32'(frame_cnt), 32'h5);

      // Reset mid-frame with timeout_err set; clear must be immediate.
      send_byte(8'h99, 4, m);
      repeat (12) @(posedge clk);
      #1;
      check("pre-reset err", 32'(timeout_err), 32'h1);
      send_byte(8'h98, 4, m);
      check("pre-reset busy", 32'(busy), 32'h1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      send_byte(8'h12, 4, m);
      check("post-reset A busy", 32'(busy), 32'h1);
      send_byte(8'h34, 4, m);
      check("post-reset alu_word", 32'(alu_word), 32'h3412);
      check("post-reset frame_cnt", 32'(frame_cnt), 32'h1);
      check("post-reset wv", 32'(m), 32'h08);

      // Strobe already high at reset release must not count as a byte.
      @(negedge clk);
      rst_n     = 1'b0;
      data_in   = 8'hEE;
      strobe_in = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("high-at-release busy", 32'(busy), 32'h0);
      strobe_in = 1'b0;
      repeat (4) @(posedge clk);
      send_byte(8'h56, 4, m);
      check("high-at-release A busy", 32'(busy), 32'h1);
      send_byte(8'h78, 4, m);
      check("high-at-release alu_word", 32'(alu_word), 32'h7856);
      check("high-at-release frame_cnt", 32'(frame_cnt), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
